// File: rtl/tt_multimode_timer.sv
// Tiny Tapeout timer core: one-shot, periodic reload, PWM and serial shift-out
// modes, all advanced by a shared prescaled tick while the FSM is in RUN.
module tt_multimode_timer #(
  parameter int CNT_W      = 8,
  parameter int PRESCALE   = 1,
  parameter bit EDGE_START = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int BIT_W = $clog2(CNT_W + 1);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(CNT_W);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {
    ONESHOT  = 2'd0,
    PERIODIC = 2'd1,
    PWM      = 2'd2,
    SERIAL   = 2'd3
  } mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             done_q, done_d;
  logic             start_prev_q, start_prev_d;

  logic start_evt, abort, tick, busy, sout, pwm;
  logic unused_ok;

  assign abort     = uio_in[1];
  assign start_evt = EDGE_START ? (uio_in[0] & ~start_prev_q) : uio_in[0];
  assign busy      = (state_q == RUN);
  assign tick      = busy && (presc_q == PRE_LAST);
  // Status pins only reflect the mode that is actually running.
  assign sout      = busy && (mode_q == SERIAL) && shreg_q[CNT_W-1];
  assign pwm       = busy && (mode_q == PWM) && (phase_q < n_q);
  assign unused_ok = &{1'b0, uio_in[7:4]};

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    n_d          = n_q;
    count_d      = count_q;
    phase_d      = phase_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    presc_d      = presc_q;
    done_d       = 1'b0;
    start_prev_d = uio_in[0];

    unique case (state_q)
      IDLE: begin
        if (start_evt && !abort) begin
          state_d = RUN;
          mode_d  = mode_t'(uio_in[3:2]);
          n_d     = CNT_W'(ui_in);
          presc_d = '0;
          unique case (mode_t'(uio_in[3:2]))
            ONESHOT, PERIODIC: count_d = CNT_W'(ui_in);
            PWM:               phase_d = '0;
            SERIAL: begin
              shreg_d  = CNT_W'(ui_in);
              bitcnt_d = BIT_FULL;
            end
          endcase
        end
      end
      RUN: begin
        // Abort freezes every counter at its current value.
        if (abort) begin
          state_d = IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            unique case (mode_q)
              ONESHOT: begin
                if (count_q != '0) begin
                  count_d = count_q - 1'b1;
                end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              end
              PERIODIC: begin
                if (count_q == '0) begin
                  count_d = n_q;
                  done_d  = 1'b1;
                end else begin
                  count_d = count_q - 1'b1;
                end
              end
              PWM: phase_d = phase_q + 1'b1;
              SERIAL: begin
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q - 1'b1;
                if (bitcnt_q == BIT_ONE) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= ONESHOT;
      n_q          <= '0;
      count_q      <= '0;
      phase_q      <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      presc_q      <= '0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      n_q          <= n_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      presc_q      <= presc_d;
      done_q       <= done_d;
      start_prev_q <= start_prev_d;
    end
  end

  always_comb begin
    uo_out = count_q[7:0];
    unique case (mode_q)
      ONESHOT, PERIODIC: uo_out = count_q[7:0];
      PWM:               uo_out = phase_q[7:0];
      SERIAL:            uo_out = shreg_q[7:0];
    endcase
  end

  assign uio_out = {pwm, sout, done_q, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_multimode_timer.sv
// Self-checking bench for tt_multimode_timer: constant vector table, directed
// corner sequences and randomized traffic against an arithmetic reference model.
module tb_tt_multimode_timer;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo    [NDUT];
  logic [7:0] uio_o [NDUT];
  logic [7:0] oe    [NDUT];

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  tt_multimode_timer #(.CNT_W(8), .PRESCALE(1), .EDGE_START(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo[0]), .uio_out(uio_o[0]), .uio_oe(oe[0]));

  tt_multimode_timer #(.CNT_W(8), .PRESCALE(3), .EDGE_START(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo[1]), .uio_out(uio_o[1]), .uio_oe(oe[1]));

  tt_multimode_timer #(.CNT_W(8), .PRESCALE(2), .EDGE_START(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo[2]), .uio_out(uio_o[2]), .uio_oe(oe[2]));

  function automatic int pre_of(int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit edge_of(int i);
    return (i != 2);
  endfunction

  // Reference model: a run is described by its mode, operand and the number
  // of enabled RUN cycles elapsed; every output is derived arithmetically.
  bit         m_run  [NDUT];
  logic [1:0] m_mode [NDUT];
  logic [7:0] m_n    [NDUT];
  int         m_k    [NDUT];
  bit         m_done [NDUT];
  bit         m_prev [NDUT];

  function automatic logic [7:0] exp_uo(int i);
    int          t;
    logic [15:0] w;
    t = m_k[i] / pre_of(i);
    case (m_mode[i])
      2'd0:    return (t >= int'(m_n[i])) ? 8'd0 : 8'(int'(m_n[i]) - t);
      2'd1:    return 8'(int'(m_n[i]) - (t % (int'(m_n[i]) + 1)));
      2'd2:    return 8'(t % 256);
      default: begin
        if (t >= 8) return 8'd0;
        w = {8'h00, m_n[i]} << t;
        return w[7:0];
      end
    endcase
  endfunction

  function automatic logic [7:0] exp_uio(int i);
    int t;
    bit s, p;
    t = m_k[i] / pre_of(i);
    s = m_run[i] && (m_mode[i] == 2'd3) && (t < 8) && m_n[i][7 - (t % 8)];
    p = m_run[i] && (m_mode[i] == 2'd2) && ((t % 256) < int'(m_n[i]));
    return {p, s, m_done[i], m_run[i], 4'b0000};
  endfunction

  task automatic model_update();
    bit sev;
    int t;
    for (int i = 0; i < NDUT; i++) begin
      if (!rst_n) begin
        m_run[i]  = 0; m_mode[i] = 2'd0; m_n[i] = 8'd0;
        m_k[i]    = 0; m_done[i] = 0;    m_prev[i] = 0;
      end else if (ena) begin
        sev       = edge_of(i) ? (uio_in[0] && !m_prev[i]) : uio_in[0];
        m_prev[i] = uio_in[0];
        m_done[i] = 0;
        if (!m_run[i]) begin
          if (sev && !uio_in[1]) begin
            m_run[i] = 1; m_mode[i] = uio_in[3:2]; m_n[i] = ui_in; m_k[i] = 0;
          end
        end else if (uio_in[1]) begin
          m_run[i] = 0;
        end else begin
          m_k[i]++;
          if (m_k[i] % pre_of(i) == 0) begin
            t = m_k[i] / pre_of(i);
            case (m_mode[i])
              2'd0: if (t == int'(m_n[i]) + 1) begin m_run[i] = 0; m_done[i] = 1; end
              2'd1: if (t % (int'(m_n[i]) + 1) == 0) m_done[i] = 1;
              2'd3: if (t == 8) begin m_run[i] = 0; m_done[i] = 1; end
              default: ;
            endcase
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input int i, input string tag);
    logic [7:0] eu, ex;
    eu = exp_uo(i);
    ex = exp_uio(i);
    n_vec++;
    if (uo[i] !== eu || uio_o[i] !== ex || oe[i] !== 8'hF0) begin
      n_mis++;
      $display("[TB] FAIL model %s dut%0d: got uo=%h uio_out=%h uio_oe=%h, expected uo=%h uio_out=%h uio_oe=f0",
               tag, i, uo[i], uio_o[i], oe[i], eu, ex);
    end
  endtask

  task automatic checkValue(input string tag, input int got, input int expv);
    n_vec++;
    if (got !== expv) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] ui,
                               input logic [7:0] uio);
    rst_n  = r;
    ena    = e;
    ui_in  = ui;
    uio_in = uio;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) checkOutput(i, tag);
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    repeat (2) step("reset");
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0);
  endtask

  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int       cnt, cnt2, at;
    logic [7:0] pat;

    // Single-step vectors for dut_a (PRESCALE=1, edge start).
    tbl.push_back('{1'b1, 1'b1, 8'd3, 8'h01, 8'd3, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd3, 8'h00, 8'd2, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd3, 8'h00, 8'd1, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd3, 8'h00, 8'd0, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd3, 8'h00, 8'd0, 8'h20});
    tbl.push_back('{1'b1, 1'b1, 8'd3, 8'h00, 8'd0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h05, 8'd2, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h04, 8'd1, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h04, 8'd0, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h04, 8'd2, 8'h30});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h04, 8'd1, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h04, 8'd0, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h04, 8'd2, 8'h30});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h06, 8'd2, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 8'd2, 8'h04, 8'd2, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0D, 8'hA5, 8'h50});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'h4A, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'h94, 8'h50});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'h28, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'h50, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'hA0, 8'h50});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'h40, 8'h10});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'h80, 8'h50});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'h00, 8'h20});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 8'h0C, 8'h00, 8'h00});

    applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    repeat (10) step("reset");
    checkValue("reset uo_out", int'(uo[0]), 0);
    checkValue("reset uio_out", int'(uio_o[0]), 0);
    checkValue("reset uio_oe", int'(oe[0]), 'hF0);

    foreach (tbl[v]) begin
      applyStimulus(tbl[v].rst_n, tbl[v].ena, tbl[v].ui, tbl[v].uio);
      step("table");
      checkValue($sformatf("table[%0d] uo_out", v), int'(uo[0]), int'(tbl[v].exp_uo));
      checkValue($sformatf("table[%0d] uio_out", v), int'(uio_o[0]), int'(tbl[v].exp_uio));
    end

    // One-shot sweep: a single done pulse N+1 cycles after the start edge.
    do_reset();
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b1, 1'b1, 8'(n), 8'h01);
      step("sweep");
      applyStimulus(1'b1, 1'b1, 8'(n), 8'h00);
      cnt = 0; at = -1;
      for (int off = 0; off <= 10; off++) begin
        if (off > 0) step("sweep");
        if (uio_o[0][5]) begin cnt++; at = off; end
      end
      if (n <= 9) begin
        checkValue($sformatf("sweep N=%0d done count", n), cnt, 1);
        checkValue($sformatf("sweep N=%0d done offset", n), at, n + 1);
      end
    end

    // PWM duty over one full phase wrap, then N=0.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      applyStimulus(1'b1, 1'b1, (pass == 0) ? 8'd64 : 8'd0, 8'h09);
      step("pwm");
      cnt = int'(uio_o[0][7]);
      applyStimulus(1'b1, 1'b1, (pass == 0) ? 8'd64 : 8'd0, 8'h08);
      for (int c = 1; c < 256; c++) begin
        step("pwm");
        cnt += int'(uio_o[0][7]);
      end
      checkValue($sformatf("pwm high cycles N=%0d", (pass == 0) ? 64 : 0), cnt,
                 (pass == 0) ? 64 : 0);
    end

    // Serial shift-out with PRESCALE=3 holds each bit for three cycles.
    do_reset();
    pat = 8'hA5;
    applyStimulus(1'b1, 1'b1, pat, 8'h0D);
    for (int j = 0; j < 24; j++) begin
      step("serial3");
      if (j == 0) applyStimulus(1'b1, 1'b1, pat, 8'h0C);
      checkValue($sformatf("serial3 bit cycle %0d", j), int'(uio_o[1][6]),
                 int'(pat[7 - j / 3]));
    end
    step("serial3");
    checkValue("serial3 done/busy", int'(uio_o[1][5:4]), 2);

    // Start held high for several cycles yields a single run.
    do_reset();
    applyStimulus(1'b1, 1'b1, 8'd2, 8'h01);
    cnt = 0; cnt2 = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) applyStimulus(1'b1, 1'b1, 8'd2, 8'h00);
      step("hold");
      cnt  += int'(uio_o[0][5]);
      cnt2 += int'(uio_o[0][4]);
    end
    checkValue("held start done count", cnt, 1);
    checkValue("held start busy cycles", cnt2, 3);

    // ena=0 freezes everything, even start and abort; then reset mid-run.
    do_reset();
    applyStimulus(1'b1, 1'b1, 8'd5, 8'h01);
    step("freeze");
    applyStimulus(1'b1, 1'b1, 8'd5, 8'h00);
    step("freeze");
    applyStimulus(1'b1, 1'b0, 8'd9, 8'h03);
    for (int c = 0; c < 3; c++) begin
      step("freeze");
      checkValue($sformatf("frozen uo_out %0d", c), int'(uo[0]), 4);
      checkValue($sformatf("frozen uio_out %0d", c), int'(uio_o[0]), 'h10);
    end
    applyStimulus(1'b1, 1'b1, 8'd9, 8'h00);
    step("freeze");
    checkValue("resume uo_out", int'(uo[0]), 3);
    applyStimulus(1'b0, 1'b1, 8'd9, 8'h00);
    step("midreset");
    checkValue("midrun reset uo_out", int'(uo[0]), 0);
    checkValue("midrun reset uio_out", int'(uio_o[0]), 0);
    checkValue("midrun reset uio_oe", int'(oe[0]), 'hF0);

    // Randomized traffic, checked every cycle against the model.
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0);
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 12)),
                    {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 3)});
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
